// File: rtl/exec_stage.sv
// exec_stage: execute stage fed by the register bank read ports.
// Computes a single-cycle ALU result or a 32-step shift-add multiply and
// holds it, with NZCV flags, in an output register that is the write-back
// source for the bank.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; in_* sampled only on accept
//   in_op, in_dest        opcode (0..11, 12-15 NOP) and destination index
//   in_a, in_b, in_imm    operands; in_use_imm selects in_imm as operand B
//   in_wb_en              write-back request
//   out_valid / out_ready downstream handshake on the result register
//   out_dest, out_data    write-back index and result
//   out_wb_en, out_flags  write-back enable, {N,Z,C,V}
//   busy                  multiply in progress
module exec_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              in_wb_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wb_en,
  output logic [3:0]        out_flags,
  output logic              busy
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned MSB  = DATA_W - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_MVN = 4'd6;
  localparam logic [3:0] OP_LSL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e state_q, state_d;

  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic [DATA_W-1:0] b_eff;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] asr_res;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              alu_wb;
  logic              c_new;
  logic              v_new;
  logic              upd_nz;

  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_next;
  logic [SH_W-1:0]   mul_cnt;
  logic [REG_AW-1:0] mul_dest;
  logic              mul_wb;

  // Handshake and operand selection
  assign in_ready = rst_n & (state_q == S_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (in_op == OP_MUL);
  assign b_eff    = in_use_imm ? in_imm : in_b;
  assign shamt    = b_eff[SH_W-1:0];
  assign add_full = {1'b0, in_a} + {1'b0, b_eff};
  assign sub_res  = in_a - b_eff;
  assign asr_res  = DATA_W'($signed(in_a) >>> shamt);

  // Multiplier: A shifts left and B shifts right each step, so bit 0 of
  // mul_b always selects the current partial product.
  assign mul_next = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_done = (state_q == S_MUL) && (mul_cnt == SH_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU result, write-back enable and next flags
  always_comb begin
    alu_res = '0;
    c_new   = out_flags[1];
    v_new   = out_flags[0];
    alu_wb  = in_wb_en;
    upd_nz  = 1'b1;
    case (in_op)
      OP_ADD: begin
        {c_new, alu_res} = add_full;
        v_new = (in_a[MSB] == b_eff[MSB]) && (add_full[MSB] != in_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_res;
        c_new   = (in_a >= b_eff);
        v_new   = (in_a[MSB] != b_eff[MSB]) && (sub_res[MSB] != in_a[MSB]);
        if (in_op == OP_CMP) alu_wb = 1'b0;
      end
      OP_AND:  alu_res = in_a & b_eff;
      OP_ORR:  alu_res = in_a | b_eff;
      OP_EOR:  alu_res = in_a ^ b_eff;
      OP_MOV:  alu_res = b_eff;
      OP_MVN:  alu_res = ~b_eff;
      OP_LSL:  alu_res = in_a << shamt;
      OP_LSR:  alu_res = in_a >> shamt;
      OP_ASR:  alu_res = asr_res;
      OP_MUL:  alu_res = '0;
      default: begin
        alu_wb = 1'b0;
        upd_nz = 1'b0;
      end
    endcase
    alu_flags = upd_nz ? {alu_res[MSB], (alu_res == '0), c_new, v_new} : out_flags;
  end

  // Output result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_wb_en <= 1'b0;
      out_flags <= '0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      out_data  <= alu_res;
      out_dest  <= in_dest;
      out_wb_en <= alu_wb;
      out_flags <= alu_flags;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      out_data  <= mul_next;
      out_dest  <= mul_dest;
      out_wb_en <= mul_wb;
      out_flags <= {mul_next[MSB], (mul_next == '0), out_flags[1:0]};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Multiply operand/accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_cnt  <= '0;
      mul_dest <= '0;
      mul_wb   <= 1'b0;
      busy     <= 1'b0;
    end else if (accept && is_mul) begin
      mul_a    <= in_a;
      mul_b    <= b_eff;
      mul_acc  <= '0;
      mul_cnt  <= '0;
      mul_dest <= in_dest;
      mul_wb   <= in_wb_en;
      busy     <= 1'b1;
    end else if (state_q == S_MUL) begin
      mul_acc <= mul_next;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt + SH_W'(1);
      if (mul_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Testbench for exec_stage: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_dest;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic        in_wb_en;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_dest;
  logic [31:0] out_data;
  logic        out_wb_en;
  logic [3:0]  out_flags;
  logic        busy;

  exec_stage #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dest(in_dest),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_wb_en(in_wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest), .out_data(out_data),
    .out_wb_en(out_wb_en), .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
    logic        wb;
    logic [3:0]  flags;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_flags;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic wb, input logic [3:0] dest, input logic [3:0] fl);
    exp_t        e;
    logic [63:0] wide;
    longint      s;
    logic        c;
    logic        v;
    logic [31:0] r;
    int          sh;
    c  = fl[1];
    v  = fl[0];
    r  = 32'd0;
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        r = wide[31:0];
        c = wide[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd1, 4'd10: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b;
      4'd6: r = ~b;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = 32'($signed(a) >>> sh);
      4'd11: begin
        wide = {32'd0, a} * {32'd0, b};
        r = wide[31:0];
      end
      default: r = 32'd0;
    endcase
    e.dest  = dest;
    e.data  = r;
    e.wb    = (op == 4'd10 || op >= 4'd12) ? 1'b0 : wb;
    e.flags = (op >= 4'd12) ? fl : {r[31], (r == 32'd0), c, v};
    e.acc   = 0;
    e.lat   = (op == 4'd11) ? 32 : 0;
    return e;
  endfunction

  // Stimulus capture: every accepted op pushes its expected result
  always @(negedge clk) begin : capture
    exp_t e;
    if (rst_n === 1'b1 && in_valid && in_ready) begin
      e = model(in_op, in_a, in_use_imm ? in_imm : in_b, in_wb_en, in_dest, m_flags);
      e.acc = cyc + 1;
      sb_q.push_back(e);
      m_flags = e.flags;
    end
  end

  // Output monitor: compare each freshly presented result, check holds
  bit          prev_v = 1'b0;
  bit          prev_r = 1'b0;
  logic [40:0] snap;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n !== 1'b1) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v || prev_r) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result got data=%h with empty scoreboard", out_data);
          end else begin
            e = sb_q[0];
            chk("result{dest,data,wb,flags}", {23'd0, out_dest, out_data, out_wb_en, out_flags},
                {23'd0, e.dest, e.data, e.wb, e.flags});
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          snap = {out_dest, out_data, out_wb_en, out_flags};
        end else begin
          chk("hold_stable", {23'd0, out_dest, out_data, out_wb_en, out_flags}, {23'd0, snap});
        end
        if (out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      end
      prev_v = out_valid;
      prev_r = out_ready;
    end
  end

  // Random backpressure
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end
  end

  // Issue one op and return just after its accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ui, input logic wb, input logic [3:0] dest);
    bit ok;
    ok = 1'b0;
    in_op = op; in_a = a; in_b = b; in_imm = imm; in_use_imm = ui; in_wb_en = wb; in_dest = dest;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for a presented result, capture it, return after the consuming edge
  task automatic wait_result(output logic [31:0] d, output logic [3:0] f, output logic w, output logic [3:0] ds);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("result_timeout", 64'(ok), 64'd1);
    d = out_data; f = out_flags; w = out_wb_en; ds = out_dest;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] d;
    logic [3:0]  f;
    logic [3:0]  ds;
    logic        w;
    int          n;
    bit          all_ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; m_flags = 4'd0;
    in_op = 4'd0; in_dest = 4'd0; in_a = '0; in_b = '0; in_imm = '0; in_use_imm = 1'b0; in_wb_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {10'd0, out_valid, busy, in_ready, out_wb_en, out_flags, out_dest, out_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ADD overflow into sign bit
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 1'b0, 1'b1, 4'd3);
    wait_result(d, f, w, ds);
    chk("add_data", 64'(d), 64'h8000_0000);
    chk("add_flags", 64'(f), 64'b1001);
    chk("add_dest", 64'(ds), 64'd3);

    // CMP suppresses write-back
    issue(4'd10, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 4'd7);
    wait_result(d, f, w, ds);
    chk("cmp_flags", 64'(f), 64'b0110);
    chk("cmp_wb_en", 64'(w), 64'd0);

    // Eight back-to-back ADDs stream at one per clock
    all_ok = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      in_op = 4'd0; in_a = 32'(i); in_b = 32'd100; in_use_imm = 1'b0; in_wb_en = 1'b1; in_dest = 4'(i);
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) all_ok = 1'b0;
      if (i > 0 && out_valid) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) n++;
    chk("b2b_in_ready", 64'(all_ok), 64'd1);
    chk("b2b_results", 64'(n), 64'd8);
    @(posedge clk); #1;

    // Set C and V so that MUL must preserve them
    issue(4'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'd1);
    wait_result(d, f, w, ds);
    chk("add_cv_flags", 64'(f), 64'b0111);

    // MUL timing: busy for 32 clocks, result on the 32nd edge
    issue(4'd11, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 1'b1, 4'd2);
    all_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!(busy && !in_ready && !out_valid)) all_ok = 1'b0;
    end
    chk("mul_busy_window", 64'(all_ok), 64'd1);
    @(negedge clk);
    chk("mul_done_handshake", {61'd0, out_valid, busy, in_ready}, 64'b101);
    chk("mul_data", 64'(out_data), 64'h0005_000F);
    chk("mul_flags", 64'(out_flags), 64'b0011);
    @(posedge clk); #1;

    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'd4);
    wait_result(d, f, w, ds);
    chk("mul2_data", 64'(d), 64'h1);
    chk("mul2_flags", 64'(f), 64'b0011);

    // Backpressure hold, then pending op accepted on the release edge
    out_ready = 1'b0;
    issue(4'd3, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, 1'b1, 4'd5);
    in_op = 4'd4; in_a = 32'h0000_00FF; in_b = 32'h0000_000F; in_use_imm = 1'b0; in_wb_en = 1'b1; in_dest = 4'd6;
    in_valid = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready || !out_valid || out_data !== 32'h0000_00FF || out_dest !== 4'd5) all_ok = 1'b0;
    end
    chk("hold_window", 64'(all_ok), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_new_result", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000_00F0});
    @(posedge clk); #1;

    // Shifts and NOP
    issue(4'd9, 32'h8000_0000, 32'h0, 32'd31, 1'b1, 1'b1, 4'd8);
    wait_result(d, f, w, ds);
    chk("asr_imm31", 64'(d), 64'hFFFF_FFFF);
    issue(4'd7, 32'h1234_5678, 32'h0, 32'd0, 1'b0, 1'b1, 4'd9);
    wait_result(d, f, w, ds);
    chk("lsl_zero", 64'(d), 64'h1234_5678);
    chk("lsl_flags", 64'(f), 64'b0011);
    issue(4'd15, 32'hDEAD_BEEF, 32'h1, 32'd0, 1'b0, 1'b1, 4'd10);
    wait_result(d, f, w, ds);
    chk("nop_out", {27'd0, d, w, f}, {27'd0, 32'd0, 1'b0, 4'b0011});

    // Reset in the middle of a multiply
    issue(4'd11, 32'd3, 32'd7, 32'd0, 1'b0, 1'b1, 4'd11);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    m_flags = 4'd0;
    #1;
    chk("midmul_reset", {57'd0, out_valid, busy, in_ready, out_flags}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_in_ready", 64'(in_ready), 64'd1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midmul_no_result", 64'(n), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(4'($urandom % 16), rnd_val(), rnd_val(), rnd_val(), 1'($urandom % 2), 1'($urandom % 2),
            4'($urandom % 16));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
